// File: rtl/boton_pulso.sv
// Push-button conditioner: 2-flop synchroniser, debounce, and a single-cycle
// count-enable pulse per press with optional auto-repeat while held.
module boton_pulso #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 12500000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_in,
    input  logic repeat_en,
    output logic pressed,
    output logic cnt_pulse
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic          sync1;
    logic          btn_s;
    logic [DW-1:0] db_cnt;
    logic          db_done;
    logic          rise;
    logic          fall;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          pulse_nxt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_in;
            btn_s <= sync1;
        end
    end

    // rise/fall are the edges on which pressed is about to toggle, so the FSM
    // reacts on the same edge and cnt_pulse lines up with pressed.
    assign db_done = (btn_s != pressed) && (db_cnt == DB_LAST);
    assign rise    = db_done & btn_s;
    assign fall    = db_done & ~btn_s;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            db_cnt  <= '0;
            pressed <= 1'b0;
        end else if (btn_s == pressed) begin
            db_cnt  <= '0;
        end else if (db_done) begin
            db_cnt  <= '0;
            pressed <= ~pressed;
        end else begin
            db_cnt  <= db_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            timer     <= '0;
            cnt_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            cnt_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = HOLD;
            HOLD: begin
                if (fall)
                    state_nxt = IDLE;
                else if (timer == '0 && repeat_en)
                    state_nxt = REPEAT;
            end
            REPEAT: begin
                if (fall)
                    state_nxt = IDLE;
                else if (!repeat_en)
                    state_nxt = HOLD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Release wins over a repeat that falls due on the same edge.
    always_comb begin
        timer_nxt = '0;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    timer_nxt = T_DELAY;
                    pulse_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (fall) begin
                    timer_nxt = '0;
                end else if (timer == '0) begin
                    if (repeat_en) begin
                        timer_nxt = T_PERIOD;
                        pulse_nxt = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            REPEAT: begin
                if (fall || !repeat_en) begin
                    timer_nxt = '0;
                end else if (timer == '0) begin
                    timer_nxt = T_PERIOD;
                    pulse_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            default: begin
                timer_nxt = '0;
                pulse_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_boton_pulso.sv
// Directed bench for boton_pulso with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; a local mod-3 counter consumes cnt_pulse.
module tb_boton_pulso;

    logic clk       = 1'b0;
    logic clr       = 1'b0;
    logic btn_in    = 1'b0;
    logic repeat_en = 1'b0;
    logic pressed;
    logic cnt_pulse;

    int unsigned checks       = 0;
    int unsigned errors       = 0;
    int unsigned pulses_total = 0;
    int unsigned seg_pulses   = 0;
    int unsigned adjacent     = 0;
    logic        prev_pulse   = 1'b0;

    logic       m3_clr = 1'b1;
    logic [1:0] m3;

    typedef struct {
        logic        btn;
        logic        ren;
        int unsigned cycles;
        logic        exp_pressed;
        int unsigned exp_pulses;
    } seg_t;

    seg_t tbl [20];
    int   pulse_at [$];
    int   exp_at [6];

    always #5 clk = ~clk;

    boton_pulso #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .pressed  (pressed),
        .cnt_pulse(cnt_pulse)
    );

    // Downstream mod-3 counter enabled by cnt_pulse.
    always_ff @(posedge clk) begin
        if (m3_clr)
            m3 <= 2'd0;
        else if (cnt_pulse)
            m3 <= (m3 == 2'd2) ? 2'd0 : m3 + 2'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cnt_pulse === 1'b1) begin
            pulses_total++;
            seg_pulses++;
            if (prev_pulse) adjacent++;
        end
        prev_pulse = cnt_pulse;
    endtask

    initial begin
        // bounce: 3 high, 2 low, 3 high, then low
        tbl[0]  = '{1'b1, 1'b0,  3, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0,  2, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0,  3, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b0, 12, 1'b0, 0};
        // clean press, no repeat; release falls on the 6th edge
        tbl[4]  = '{1'b1, 1'b0, 50, 1'b1, 1};
        tbl[5]  = '{1'b0, 1'b0,  5, 1'b1, 0};
        tbl[6]  = '{1'b0, 1'b0,  1, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b0,  5, 1'b0, 0};
        // auto-repeat: pulses 5,15,18,21,24 | 27 | none at release edge 30
        tbl[8]  = '{1'b1, 1'b1, 25, 1'b1, 5};
        tbl[9]  = '{0, 1'b1,  5, 1'b1, 1};
        tbl[10] = '{1'b0, 1'b1,  1, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b1,  8, 1'b0, 0};
        // repeat_en toggling while held: pulses 5 | 20 | 23 | none | 30
        tbl[12] = '{1'b1, 1'b0, 20, 1'b1, 1};
        tbl[13] = '{1'b1, 1'b1,  1, 1'b1, 1};
        tbl[14] = '{1'b1, 1'b1,  3, 1'b1, 1};
        tbl[15] = '{1'b1, 1'b0,  6, 1'b1, 0};
        tbl[16] = '{1'b1, 1'b1,  1, 1'b1, 1};
        tbl[17] = '{1'b0, 1'b0,  5, 1'b1, 0};
        tbl[18] = '{1'b0, 1'b0,  1, 1'b0, 0};
        tbl[19] = '{1'b0, 1'b0,  3, 1'b0, 0};
        exp_at  = '{5, 15, 18, 21, 24, 27};

        // reset held with the button down
        clr    = 1'b1;
        btn_in = 1'b1;
        #1;
        chk("async_rst_pressed", pressed, 0);
        chk("async_rst_pulse", cnt_pulse, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_pressed", pressed, 0);
            chk("rst_pulse", cnt_pulse, 0);
        end
        clr    = 1'b0;
        m3_clr = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk($sformatf("post_rst_pulse_e%0d", e), cnt_pulse, (e == 6) ? 1 : 0);
            chk($sformatf("post_rst_pressed_e%0d", e), pressed, (e >= 6) ? 1 : 0);
        end
        btn_in = 1'b0;
        for (int e = 11; e <= 16; e++) begin
            step();
            chk($sformatf("rel_pressed_e%0d", e), pressed, (e < 16) ? 1 : 0);
            chk($sformatf("rel_pulse_e%0d", e), cnt_pulse, 0);
        end
        chk("m3_after_first", m3, 1);

        for (int s = 0; s < 20; s++) begin
            btn_in     = tbl[s].btn;
            repeat_en  = tbl[s].ren;
            seg_pulses = 0;
            for (int c = 0; c < int'(tbl[s].cycles); c++) step();
            chk($sformatf("seg%0d_pressed", s), pressed, tbl[s].exp_pressed);
            chk($sformatf("seg%0d_pulses", s), seg_pulses, tbl[s].exp_pulses);
        end

        // exact repeat timing, release coinciding with a due repeat at edge 30
        repeat_en = 1'b1;
        for (int e = 0; e < 36; e++) begin
            btn_in = (e < 25);
            step();
            if (cnt_pulse === 1'b1) pulse_at.push_back(e);
            if (e == 29) chk("hold_pressed_e29", pressed, 1);
            if (e == 30) begin
                chk("release_pressed_e30", pressed, 0);
                chk("release_pulse_e30", cnt_pulse, 0);
            end
        end
        chk("repeat_count", pulse_at.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < pulse_at.size())
                chk($sformatf("repeat_edge%0d", i), pulse_at[i], exp_at[i]);
            else
                chk($sformatf("repeat_edge%0d", i), 32'hFFFF_FFFF, exp_at[i]);
        end

        // reset in the middle of REPEAT (after edge 19, pulses at 5,15,18)
        btn_in    = 1'b1;
        repeat_en = 1'b1;
        for (int e = 0; e < 20; e++) step();
        chk("mid_rep_pressed", pressed, 1);
        #2;
        clr = 1'b1;
        #1;
        chk("mid_rst_pressed", pressed, 0);
        chk("mid_rst_pulse", cnt_pulse, 0);
        btn_in = 1'b0;
        step();
        step();
        clr = 1'b0;
        seg_pulses = 0;
        for (int e = 0; e < 10; e++) step();
        chk("after_mid_rst_pulses", seg_pulses, 0);
        chk("after_mid_rst_pressed", pressed, 0);

        chk("total_pulses", pulses_total, 21);
        chk("m3_count", m3, 21 % 3);
        chk("adjacent_pulses", adjacent, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
